// File: rtl/shift_sub_div512.sv
// Restoring shift-subtract divider: 2N-bit dividend / N-bit divisor -> N-bit quotient and remainder.
// Optional macro SHIFT_SUB_DIV_RADIX4_EN chains two restoring steps per clock (N/2 RUN cycles).
module shift_sub_div512 #(
    parameter int unsigned N = 256
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic           div_by_zero,
    output logic           overflow
);

    localparam int unsigned CW = $clog2(N);
`ifdef SHIFT_SUB_DIV_RADIX4_EN
    localparam int unsigned ITERS = N / 2;
`else
    localparam int unsigned ITERS = N;
`endif
    localparam logic [CW-1:0] CNT_LAST = CW'(ITERS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // One restoring step. The partial remainder stays below the divisor after every
    // step, so its top bit is always zero and only the low N bits are carried.
    function automatic logic [2*N-1:0] div_step(
        input logic [N-1:0] r,
        input logic [N-1:0] q,
        input logic [N-1:0] d
    );
        logic [N:0]   t;
        logic [N-1:0] r_new;
        logic         qbit;
        t = {r, q[N-1]};
        if (t >= {1'b0, d}) begin
            r_new = t[N-1:0] - d;
            qbit  = 1'b1;
        end else begin
            r_new = t[N-1:0];
            qbit  = 1'b0;
        end
        return {r_new, q[N-2:0], qbit};
    endfunction

    logic [1:0]     r_state;
    logic [N-1:0]   r_prem;
    logic [N-1:0]   r_q;
    logic [N-1:0]   r_dvs;
    logic [CW-1:0]  r_cnt;
    logic [N-1:0]   r_quot;
    logic [N-1:0]   r_rem;
    logic           r_dz;
    logic           r_ov;
    logic           r_busy;
    logic           r_done;

    logic [1:0]     w_state_nxt;
    logic [N-1:0]   w_prem_nxt;
    logic [N-1:0]   w_q_nxt;
    logic [N-1:0]   w_dvs_nxt;
    logic [CW-1:0]  w_cnt_nxt;
    logic [N-1:0]   w_quot_nxt;
    logic [N-1:0]   w_rem_nxt;
    logic           w_dz_nxt;
    logic           w_ov_nxt;
    logic           w_busy_nxt;
    logic           w_done_nxt;

    logic [N-1:0]   w_div_hi;
    logic [2*N-1:0] w_step1;
    logic [2*N-1:0] w_step;

    assign w_div_hi = dividend[2*N-1:N];
    assign w_step1  = div_step(r_prem, r_q, r_dvs);

`ifdef SHIFT_SUB_DIV_RADIX4_EN
    assign w_step = div_step(w_step1[2*N-1:N], w_step1[N-1:0], r_dvs);
`else
    assign w_step = w_step1;
`endif

    // Next-state and datapath update
    always_comb begin
        w_state_nxt = r_state;
        w_prem_nxt  = r_prem;
        w_q_nxt     = r_q;
        w_dvs_nxt   = r_dvs;
        w_cnt_nxt   = r_cnt;
        w_quot_nxt  = r_quot;
        w_rem_nxt   = r_rem;
        w_dz_nxt    = r_dz;
        w_ov_nxt    = r_ov;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;

        case (r_state)
            S_IDLE, S_DONE: begin
                w_state_nxt = S_IDLE;
                if (start) begin
                    if (divisor == '0) begin
                        w_dz_nxt    = 1'b1;
                        w_ov_nxt    = 1'b0;
                        w_quot_nxt  = '1;
                        w_rem_nxt   = '0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_DONE;
                    end else if (w_div_hi >= divisor) begin
                        w_dz_nxt    = 1'b0;
                        w_ov_nxt    = 1'b1;
                        w_quot_nxt  = '1;
                        w_rem_nxt   = '0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_prem_nxt  = w_div_hi;
                        w_q_nxt     = dividend[N-1:0];
                        w_dvs_nxt   = divisor;
                        w_cnt_nxt   = '0;
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = S_RUN;
                    end
                end
            end
            S_RUN: begin
                w_busy_nxt = 1'b1;
                w_prem_nxt = w_step[2*N-1:N];
                w_q_nxt    = w_step[N-1:0];
                w_cnt_nxt  = r_cnt + CW'(1);
                if (r_cnt == CNT_LAST) begin
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_quot_nxt  = w_step[N-1:0];
                    w_rem_nxt   = w_step[2*N-1:N];
                    w_dz_nxt    = 1'b0;
                    w_ov_nxt    = 1'b0;
                    w_state_nxt = S_DONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_prem  <= '0;
            r_q     <= '0;
            r_dvs   <= '0;
            r_cnt   <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_dz    <= 1'b0;
            r_ov    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_prem  <= w_prem_nxt;
            r_q     <= w_q_nxt;
            r_dvs   <= w_dvs_nxt;
            r_cnt   <= w_cnt_nxt;
            r_quot  <= w_quot_nxt;
            r_rem   <= w_rem_nxt;
            r_dz    <= w_dz_nxt;
            r_ov    <= w_ov_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dz;
    assign overflow    = r_ov;

endmodule

// File: tb/tb_shift_sub_div512.sv
// Bench for shift_sub_div512: N=8 and N=256 instances against a transaction-level division model.
// Honours SHIFT_SUB_DIV_RADIX4_EN for the expected RUN length.
module tb_shift_sub_div512;

`ifdef SHIFT_SUB_DIV_RADIX4_EN
    localparam int B8   = 4;
    localparam int B256 = 128;
`else
    localparam int B8   = 8;
    localparam int B256 = 256;
`endif
    localparam int LAT8   = B8 + 1;
    localparam int LAT256 = B256 + 1;

    typedef struct {
        logic [255:0] q;
        logic [255:0] r;
        logic [255:0] pq;
        logic [255:0] pr;
        bit           dz;
        bit           ov;
        bit           busy;
        bit           done;
        int           remain;
    } mdl_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           start8;
    logic [15:0]    dividend8;
    logic [7:0]     divisor8;
    logic           busy8, done8, dz8, ov8;
    logic [7:0]     quotient8, remainder8;

    logic           start256;
    logic [511:0]   dividend256;
    logic [255:0]   divisor256;
    logic           busy256, done256, dz256, ov256;
    logic [255:0]   quotient256, remainder256;

    int n_checks = 0;
    int n_err    = 0;

    mdl_t m8, m256;

    shift_sub_div512 #(.N(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .dividend(dividend8), .divisor(divisor8),
        .busy(busy8), .done(done8), .quotient(quotient8), .remainder(remainder8),
        .div_by_zero(dz8), .overflow(ov8)
    );

    shift_sub_div512 #(.N(256)) u_dut256 (
        .clk(clk), .rst(rst), .start(start256), .dividend(dividend256), .divisor(divisor256),
        .busy(busy256), .done(done256), .quotient(quotient256), .remainder(remainder256),
        .div_by_zero(dz256), .overflow(ov256)
    );

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic mdl_t mreset();
        mdl_t o;
        o.q = '0; o.r = '0; o.pq = '0; o.pr = '0;
        o.dz = 0; o.ov = 0; o.busy = 0; o.done = 0; o.remain = 0;
        return o;
    endfunction

    // One clock of the reference: results come from plain / and %, timing from the latency rules.
    function automatic mdl_t mstep(mdl_t m, bit st, logic [511:0] dvd, logic [255:0] dvs,
                                   int n, int bcyc);
        mdl_t         o;
        logic [255:0] ones;
        logic [511:0] hi;
        logic [511:0] tmp;
        o      = m;
        ones   = (256'(1) << n) - 256'(1);
        o.done = 0;
        if (m.remain > 0) begin
            o.remain = m.remain - 1;
            if (o.remain == 0) begin
                o.done = 1; o.q = m.pq; o.r = m.pr; o.dz = 0; o.ov = 0;
            end
        end
        if (st && m.remain == 0) begin
            hi = dvd >> n;
            if (dvs == '0) begin
                o.done = 1; o.q = ones; o.r = '0; o.dz = 1; o.ov = 0;
            end else if (hi >= {256'b0, dvs}) begin
                o.done = 1; o.q = ones; o.r = '0; o.dz = 0; o.ov = 1;
            end else begin
                tmp      = dvd / {256'b0, dvs};
                o.pq     = tmp[255:0];
                tmp      = dvd % {256'b0, dvs};
                o.pr     = tmp[255:0];
                o.remain = bcyc;
            end
        end
        o.busy = (o.remain > 0);
        return o;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m8   <= mreset();
            m256 <= mreset();
        end else begin
            m8   <= mstep(m8, start8, 512'(dividend8), 256'(divisor8), 8, B8);
            m256 <= mstep(m256, start256, dividend256, divisor256, 256, B256);
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        chk("busy8", 256'(busy8), 256'(m8.busy));
        chk("done8", 256'(done8), 256'(m8.done));
        chk("quot8", 256'(quotient8), m8.q);
        chk("rem8", 256'(remainder8), m8.r);
        if (m8.done) begin
            chk("dz8", 256'(dz8), 256'(m8.dz));
            chk("ov8", 256'(ov8), 256'(m8.ov));
        end
        chk("busy256", 256'(busy256), 256'(m256.busy));
        chk("done256", 256'(done256), 256'(m256.done));
        chk("quot256", quotient256, m256.q);
        chk("rem256", remainder256, m256.r);
        if (m256.done) begin
            chk("dz256", 256'(dz256), 256'(m256.dz));
            chk("ov256", 256'(ov256), 256'(m256.ov));
        end
    end

    task automatic go8(input logic [15:0] a, input logic [7:0] b);
        @(negedge clk);
        start8 = 1'b1; dividend8 = a; divisor8 = b;
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic wait_done8(input int budget, output int cyc);
        cyc = 1;
        while (done8 !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        if (done8 !== 1'b1) begin
            n_checks++; n_err++;
            $display("FAIL timeout8: done not seen within %0d cycles", budget);
        end
    endtask

    task automatic run8(input string nm, input logic [15:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er, input bit edz,
                        input bit eov, input int elat);
        int cyc;
        go8(a, b);
        wait_done8(40, cyc);
        chk({nm, "_lat"}, 256'(cyc), 256'(elat));
        chk({nm, "_q"}, 256'(quotient8), 256'(eq));
        chk({nm, "_r"}, 256'(remainder8), 256'(er));
        chk({nm, "_dz"}, 256'(dz8), 256'(edz));
        chk({nm, "_ov"}, 256'(ov8), 256'(eov));
        chk({nm, "_mq"}, m8.q, 256'(eq));
        chk({nm, "_busy"}, 256'(busy8), 256'(0));
    endtask

    initial begin
        int           cyc;
        logic [511:0] big;
        rst = 1'b1;
        start8 = 1'b0; dividend8 = '0; divisor8 = '0;
        start256 = 1'b0; dividend256 = '0; divisor256 = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 256'(busy8), 256'(0));
        chk("rst_done", 256'(done8), 256'(0));
        chk("rst_q", 256'(quotient8), 256'(0));
        chk("rst_r", 256'(remainder8), 256'(0));
        chk("rst_dz", 256'(dz8), 256'(0));
        chk("rst_ov", 256'(ov8), 256'(0));
        rst = 1'b0;

        run8("t1", 16'h1234, 8'h56, 8'h36, 8'h10, 0, 0, LAT8);
        run8("t2", 16'h0042, 8'h00, 8'hFF, 8'h00, 1, 0, 1);
        run8("t3", 16'h5600, 8'h56, 8'hFF, 8'h00, 0, 1, 1);
        run8("edge_hi", 16'h55FF, 8'h56, 8'hFF, 8'h55, 0, 0, LAT8);
        run8("edge_one", 16'h00FF, 8'hFF, 8'h01, 8'h00, 0, 0, LAT8);
        run8("ov_max", 16'hFFFF, 8'h01, 8'hFF, 8'h00, 0, 1, 1);

        // start during RUN is ignored
        go8(16'h1234, 8'h56);
        @(negedge clk);
        start8 = 1'b1; dividend8 = 16'h00FF; divisor8 = 8'h10;
        @(negedge clk);
        start8 = 1'b0;
        wait_done8(40, cyc);
        chk("t5_q", 256'(quotient8), 256'(8'h36));
        chk("t5_r", 256'(remainder8), 256'(8'h10));

        // asynchronous reset mid-run
        go8(16'h1234, 8'h56);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_busy", 256'(busy8), 256'(0));
        chk("t5_rst_done", 256'(done8), 256'(0));
        chk("t5_rst_q", 256'(quotient8), 256'(0));
        chk("t5_rst_r", 256'(remainder8), 256'(0));
        chk("t5_rst_dz", 256'(dz8), 256'(0));
        chk("t5_rst_ov", 256'(ov8), 256'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            chk("t5_nodone", 256'(done8), 256'(0));
        end

        // back-to-back with start held through the done cycle
        @(negedge clk);
        start8 = 1'b1; dividend8 = 16'h1234; divisor8 = 8'h56;
        @(negedge clk);
        wait_done8(40, cyc);
        chk("t6a_lat", 256'(cyc), 256'(LAT8));
        chk("t6a_q", 256'(quotient8), 256'(8'h36));
        chk("t6a_r", 256'(remainder8), 256'(8'h10));
        dividend8 = 16'h00FF; divisor8 = 8'h10;
        @(negedge clk);
        start8 = 1'b0;
        wait_done8(40, cyc);
        chk("t6b_lat", 256'(cyc), 256'(LAT8));
        chk("t6b_q", 256'(quotient8), 256'(8'h0F));
        chk("t6b_r", 256'(remainder8), 256'(8'h0F));

        // N=256 large operands
        big = {256'b0, {256{1'b1}}} * {256'b0, ~256'd1} + 512'd5;
        @(negedge clk);
        start256 = 1'b1; dividend256 = big; divisor256 = '1;
        @(negedge clk);
        start256 = 1'b0;
        cyc = 1;
        while (done256 !== 1'b1 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        if (done256 !== 1'b1) begin
            n_checks++; n_err++;
            $display("FAIL timeout256: done not seen within 400 cycles");
        end
        chk("t4_lat", 256'(cyc), 256'(LAT256));
        chk("t4_q", quotient256, ~256'd1);
        chk("t4_r", remainder256, 256'd5);
        chk("t4_dz", 256'(dz256), 256'(0));
        chk("t4_ov", 256'(ov256), 256'(0));
        chk("t4_mq", m256.q, ~256'd1);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/shift_sub_div512.md
Name: shift_sub_div512

Overview:
- Sequential restoring shift-subtract divider; the inverse of the shift-add multiply path in the MAC datapath.
- Divides a 2N-bit dividend (a MAC accumulator value) by an N-bit divisor.
- Produces an N-bit quotient and an N-bit remainder, one quotient bit per clock.
- Used to scale and normalize 512-bit accumulator results back to 256-bit operands.

Parameters:
- N, 256, divisor/quotient/remainder width; dividend is 2N bits; N must be even and >= 4.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled on the rising edge.
- dividend  input  2N  dividend; captured on the accepted start.
- divisor  input  N  divisor; captured on the accepted start.
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse when results are updated.
- quotient  output  N  result quotient; held between operations.
- remainder  output  N  result remainder; held between operations.
- div_by_zero  output  1  set when divisor == 0.
- overflow  output  1  set when dividend[2N-1:N] >= divisor, divisor nonzero.

Behaviour:
- Reset (rst=1, any time, asynchronous):
  - State goes to IDLE.
  - busy, done, quotient, remainder, div_by_zero and overflow are all 0.
  - Any in-flight operation is discarded.
- States: IDLE, RUN, DONE.
- IDLE, or DONE, with start=1 (edge k): capture operands and clear both flags, then:
  - divisor==0: div_by_zero=1, quotient=all ones, remainder=0, go to DONE. done is high in cycle k+1.
  - else if dividend[2N-1:N] >= divisor: overflow=1, quotient=all ones, remainder=0, go to DONE. done is high in cycle k+1.
  - else: go to RUN. Partial remainder R (N+1 bits) = {0, dividend[2N-1:N]}. Shift register Q = dividend[N-1:0]. Iteration counter = 0.
- start while busy is ignored; no queuing.
- RUN, each cycle:
  - T = {R[N-1:0], Q[N-1]} (N+1 bits).
  - If T >= {0, divisor}: R = T - divisor and the shifted-in quotient bit is 1.
  - Else: R = T and the shifted-in quotient bit is 0.
  - Q = {Q[N-2:0], qbit}.
  - Counter increments. After iteration N-1, load quotient=Q and remainder=R[N-1:0], then go to DONE.
- Timing for the normal path:
  - busy is high in cycles k+1 .. k+N.
  - done is high in cycle k+N+1.
  - Total latency is N+1 cycles from start.
- DONE: done=1 and busy=0 for exactly one cycle.
  - Next state is IDLE, or capture if start=1 (back-to-back operation).
- quotient, remainder and the flags change only on the done cycle or on reset. They hold their values otherwise.
- Arithmetic is unsigned throughout.
- In the normal path, the invariant R < divisor holds after every iteration, so the quotient fits in N bits.
- Counter width is clog2(N). It must not wrap before the final iteration.

Optional Feature:
- Macro: SHIFT_SUB_DIV_RADIX4_EN.
- Defined: two restoring iterations are chained combinationally per clock.
  - RUN lasts N/2 cycles; done is high in cycle k+N/2+1.
  - Results are bit-identical to the radix-2 build.
- Undefined: one iteration per clock, as specified above.
- The error paths (div_by_zero, overflow) have one-cycle latency in both builds.

Test Plan:
1. N=8: dividend=16'h1234, divisor=8'h56, start pulse -> busy for 8 cycles; done at k+9; quotient=8'h36, remainder=8'h10, both flags 0.
2. N=8: divisor=8'h00, dividend=16'h0042 -> done at k+1, div_by_zero=1, quotient=8'hFF, remainder=8'h00, busy never high.
3. N=8: dividend=16'h5600, divisor=8'h56 -> done at k+1, overflow=1, quotient=8'hFF, remainder=0.
4. N=256: divisor=2^256-1, dividend=(2^256-1)*(2^256-2)+5 -> done at k+257, quotient=2^256-2, remainder=5.
5. N=8, case 1 running: pulse start with new operands at cycle k+3 -> ignored, results still 8'h36/8'h10. Then assert rst at cycle k+5 -> all outputs 0 immediately, IDLE, no done pulse.
6. N=8: start held high through the done cycle with new operands 16'h00FF / 8'h10 -> first done gives 8'h36/8'h10; second done 9 cycles later gives quotient=8'h0F, remainder=8'h0F. Repeat both cases with SHIFT_SUB_DIV_RADIX4_EN defined -> same values, done at k+5.
